// File: rtl/fifo_pkt_writer_if.sv
// Upstream valid/ready payload stream plus the FIFO write port of fifo_pkt_writer.
// master: the packet writer; slave: the upstream source / FIFO side.
interface fifo_pkt_writer_if #(
    parameter int unsigned DATA = 8
);
    logic            s_valid;
    logic [DATA-1:0] s_data;
    logic            s_last;
    logic            s_ready;
    logic            full;
    logic            w_en;
    logic [DATA-1:0] wdata;

    modport master (
        input  s_valid, s_data, s_last, full,
        output s_ready, w_en, wdata
    );

    modport slave (
        output s_valid, s_data, s_last, full,
        input  s_ready, w_en, wdata
    );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer: header (seq), payload, optional XOR trailer into an async FIFO.
// Trailer state and checksum are built only when PKT_WRITER_TRAILER_EN is defined.
module fifo_pkt_writer #(
    parameter int unsigned DATA  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               en,
    fifo_pkt_writer_if.master  bus,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        TRL  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DATA-1:0] seq;
    logic            xfer;
    logic            hdr_wr;
    logic            pkt_done;
    logic            stall_pend;
    logic            w_en_c;
    logic            s_ready_c;
    logic [DATA-1:0] wdata_c;

    // Event decode shared by the FSM and the datapath registers
    assign xfer       = (state == BODY) && bus.s_valid && !bus.full;
    assign hdr_wr     = (state == HDR) && !bus.full;
    assign stall_pend = (state == HDR) || (state == TRL) || ((state == BODY) && bus.s_valid);

`ifdef PKT_WRITER_TRAILER_EN
    logic [DATA-1:0] csum;
    assign pkt_done = (state == TRL) && !bus.full;
`else
    assign pkt_done = xfer && bus.s_last;
`endif

    // State register; busy mirrors the registered state
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && bus.s_valid) state_nxt = HDR;
            end
            HDR: begin
                if (hdr_wr) state_nxt = BODY;
            end
            BODY: begin
`ifdef PKT_WRITER_TRAILER_EN
                if (xfer && bus.s_last) state_nxt = TRL;
`else
                if (pkt_done) state_nxt = IDLE;
`endif
            end
`ifdef PKT_WRITER_TRAILER_EN
            TRL: begin
                if (pkt_done) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: write strobe, write data and upstream ready
    always_comb begin
        w_en_c    = 1'b0;
        s_ready_c = 1'b0;
        wdata_c   = '0;
        case (state)
            HDR: begin
                w_en_c  = !bus.full;
                wdata_c = seq;
            end
            BODY: begin
                w_en_c    = bus.s_valid && !bus.full;
                s_ready_c = !bus.full;
                wdata_c   = bus.s_data;
            end
`ifdef PKT_WRITER_TRAILER_EN
            TRL: begin
                w_en_c  = !bus.full;
                wdata_c = csum;
            end
`endif
            default: begin
                w_en_c    = 1'b0;
                s_ready_c = 1'b0;
                wdata_c   = '0;
            end
        endcase
    end

    assign bus.w_en    = w_en_c;
    assign bus.s_ready = s_ready_c;
    assign bus.wdata   = wdata_c;

    // Sequence number and statistics counters
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            seq       <= '0;
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pkt_done) begin
                seq     <= seq + DATA'(1);
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (stall_pend && bus.full && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PKT_WRITER_TRAILER_EN
    // Running XOR of the payload, cleared as the header goes out
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            csum <= '0;
        end else if (hdr_wr) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ bus.s_data;
        end
    end
`endif

endmodule
